// File: rtl/csd_shift_add_mult.sv
// Multiplierless constant multiplier: streams CSD digits MSB first from a synchronous
// digit memory and forms x * constant by Horner shift-add/subtract, one digit per cycle.
module csd_shift_add_mult #(
  parameter int unsigned WX   = 8,
  parameter int unsigned NDIG = 16,
  parameter int unsigned AW   = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [WX-1:0]        i_x_in,
  output logic                 o_rd_en,
  output logic [AW-1:0]        o_rd_addr,
  input  logic [1:0]           i_rd_data,
  output logic [WX+NDIG-1:0]   o_product,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err
);

  localparam int unsigned PW = WX + NDIG;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [AW-1:0] CntInit = AW'(NDIG - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_cnt;
  logic [WX-1:0] r_x;
  logic          r_valid_d;
  logic [PW-1:0] r_acc;
  logic [PW-1:0] r_product;
  logic          r_err;

  logic [PW-1:0] w_x_ext;
  logic [PW-1:0] w_acc_shl;
  logic [PW-1:0] w_acc_next;
  logic          w_illegal;

  assign w_x_ext   = {{NDIG{r_x[WX-1]}}, r_x};
  assign w_acc_shl = {r_acc[PW-2:0], 1'b0};
  assign w_illegal = (i_rd_data == 2'b10);

  // Illegal code 10 falls through to the zero-digit path.
  always_comb begin
    w_acc_next = w_acc_shl;
    case (i_rd_data)
      2'b01:   w_acc_next = w_acc_shl + w_x_ext;
      2'b11:   w_acc_next = w_acc_shl - w_x_ext;
      default: w_acc_next = w_acc_shl;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_x       <= '0;
      r_valid_d <= 1'b0;
      r_acc     <= '0;
      r_product <= '0;
      r_err     <= 1'b0;
    end else begin
      r_valid_d <= o_rd_en;
      if (r_valid_d) begin
        r_acc <= w_acc_next;
        if (w_illegal) r_err <= 1'b1;
      end
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StRun;
            r_x     <= i_x_in;
            r_acc   <= '0;
            r_cnt   <= CntInit;
            r_err   <= 1'b0;
          end
        end
        StRun: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= StDrain;
        end
        StDrain: begin
          // Address 0 lands this edge, so capture the updated sum directly.
          r_state   <= StDone;
          r_product <= w_acc_next;
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rd_en   = (r_state == StRun);
  assign o_rd_addr = o_rd_en ? r_cnt : '0;
  assign o_product = r_product;
  assign o_busy    = (r_state == StRun) || (r_state == StDrain);
  assign o_done    = (r_state == StDone);
  assign o_err     = r_err;

endmodule

// File: doc/csd_shift_add_mult.md
Name: csd_shift_add_mult

Overview:
- Downstream consumer of the CSD digit memory filled by the ASD-to-CSD converter.
- After start, reads NDIG signed digits serially, MSB first, through a synchronous read port.
- Computes signed product = x_in × (CSD constant) by Horner shift-add/subtract, one digit per cycle, then signals done.
- Lets the team use a converted CSD constant as a multiplierless coefficient.

Parameters:
- WX, 8, width of signed multiplicand x_in (two's complement).
- NDIG, 16, number of CSD digits read; 1 ≤ NDIG ≤ 2^AW.
- AW, 4, digit memory address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level request; accepted only in IDLE.
- x_in  in  WX  signed multiplicand; sampled on the start-acceptance edge.
- rd_en  out  1  digit memory read enable.
- rd_addr  out  AW  digit address; address 0 = weight 2^0 (LSB).
- rd_data  in  2  digit code, valid the cycle after rd_en: 00 = 0, 01 = +1, 11 = −1, 10 = illegal.
- product  out  WX+NDIG  signed result; held until the next completion.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse in DONE; product is valid that cycle.
- err  out  1  sticky flag: an illegal code was read in the current/last operation.

Behaviour:
- Reset (synchronous, priority over everything): state = IDLE; acc, product, counter, x_reg, valid_d, err = 0; busy = done = 0. rd_en = 0 and rd_addr = 0 from the cycle after the reset edge.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, start = 1 at an edge:
  - Next state RUN; x_reg ← x_in; acc ← 0; cnt ← NDIG−1; err ← 0.
  - start = 0: stay in IDLE.
- RUN:
  - rd_en = 1, rd_addr = cnt, both decoded from registered state and cnt.
  - Each edge: cnt ← cnt−1.
  - When cnt = 0 at an edge, next state DRAIN. RUN lasts exactly NDIG cycles.
- valid_d ← rd_en, registered. On each edge with valid_d = 1: acc ← (acc <<< 1) + d·sext(x_reg), where d ∈ {−1, 0, +1} is decoded from rd_data.
- DRAIN: rd_en = 0; the last digit (address 0) is accumulated at the end of this cycle; next state DONE.
- DONE:
  - product shows the final acc (register loaded on DRAIN→DONE edge); done = 1; busy = 0.
  - Next state is IDLE unconditionally.
  - start sampled in DONE is ignored. If start is held high, a new operation starts from the following IDLE cycle.
- Latency: start accepted at edge of cycle 0 → RUN cycles 1..NDIG → DRAIN cycle NDIG+1 → done = 1 in cycle NDIG+2. Next acceptance at the earliest in cycle NDIG+3.
- Width and arithmetic:
  - acc and product are WX+NDIG bits, signed, with x_reg sign-extended.
  - |constant| ≤ 2^NDIG−1, so no overflow is possible; no saturation logic.
  - Shift is arithmetic; all arithmetic is two's complement, truncated to WX+NDIG bits.
- Illegal code 10: treated as digit 0; err ← 1 and stays set until the next start acceptance or reset.
- start while busy or in DONE: ignored. x_in changes after acceptance have no effect.
- Reset mid-operation: abort immediately to IDLE with all registers cleared. No done pulse; product is cleared to 0.
- rd_data is ignored whenever valid_d = 0.

Test Plan:
- Basic multiply: NDIG = 16, WX = 8; digits addr0 = +1, addr1 = +1, addr2 = 0, addr3 = +1, others 0 (constant 11); x_in = 5; start pulsed in cycle 0.
  - rd_addr steps 15..0 in cycles 1–16.
  - done = 1 only in cycle 18; product = 55; err = 0.
- Negative operands: addr4 = +1, addr0 = −1 (constant 15); x_in = −3 → product = −45 (24-bit 0xFFFFD3).
- Extreme: all 16 digits = −1 (constant −65535); x_in = −128 → product = 8388480 (0x7FFF80); no wrap.
- Illegal code: addr2 = 10, addr0 = +1, rest 0; x_in = 7 → product = 7; err = 1 from the accumulation edge onward. A second start with clean digits clears err to 0 on acceptance.
- Handshake: start held high continuously with x_in = 2, constant 11.
  - done pulses in cycles 18 and 37 with product = 22 both times.
  - start toggled during RUN is ignored; busy is high in cycles 1–17.
- Reset mid-operation: reset asserted for one edge in cycle 7 of a run.
  - Next cycle: state IDLE; rd_en = 0, busy = 0, product = 0, err = 0.
  - No done pulse occurs; a subsequent start computes the correct product.
